// File: rtl/adma_pkg.sv
// Shared types and helpers for the AXI DMA channel arbiter.
// Holds the arbiter state encoding and the channel-index width helper.
package adma_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } adma_arb_state_e;

   // Width of a channel index; never narrower than one bit
   function automatic int chn_id_w(input int chn_num);
      return (chn_num <= 1) ? 1 : $clog2(chn_num);
   endfunction

endpackage

// File: rtl/adma_rr_pick.sv
// Rotating-priority picker: returns the first eligible channel scanning from ptr upward.
// Purely combinational; the owner of the scan pointer is the arbiter FSM.
module adma_rr_pick
   import adma_pkg::*;
#(
   parameter int DMA_CHN_NUM = 4,
   parameter int CHN_ID_W    = chn_id_w(DMA_CHN_NUM)
) (
   input  logic [DMA_CHN_NUM-1:0] elig,
   input  logic [CHN_ID_W-1:0]    ptr,
   output logic                   pick_vld,
   output logic [CHN_ID_W-1:0]    pick_idx
);

   logic                pick_vld_s;
   logic [CHN_ID_W-1:0] pick_idx_s;
   int                  idx_s;

   // Scan from the farthest offset down so the nearest eligible channel wins
   always_comb begin
      pick_vld_s = 1'b0;
      pick_idx_s = '0;
      idx_s      = 0;
      for (int i = DMA_CHN_NUM - 1; i >= 0; i--) begin
         idx_s = (int'(ptr) + i) % DMA_CHN_NUM;
         if (elig[CHN_ID_W'(idx_s)]) begin
            pick_vld_s = 1'b1;
            pick_idx_s = CHN_ID_W'(idx_s);
         end else begin
            pick_vld_s = pick_vld_s;
            pick_idx_s = pick_idx_s;
         end
      end
   end

   assign pick_vld = pick_vld_s;
   assign pick_idx = pick_idx_s;

endmodule

// File: rtl/adma_chn_arb.sv
// Weighted round-robin arbiter sharing the AXI4 master datapath between DMA channels.
// A granted channel may issue up to its weight in bursts before ownership rotates.
module adma_chn_arb
   import adma_pkg::*;
#(
   parameter  int DMA_CHN_NUM   = 4,
   parameter  int DMA_CHN_ARB_W = 3,
   localparam int CHN_ID_W      = chn_id_w(DMA_CHN_NUM)
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     dma_en_i,
   input  logic                     chn_ctrl_en_i  [0:DMA_CHN_NUM-1],
   input  logic [DMA_CHN_ARB_W-1:0] chn_arb_rate_i [0:DMA_CHN_NUM-1],
   input  logic                     chn_req_i      [0:DMA_CHN_NUM-1],
   output logic                     grant_vld_o,
   output logic [CHN_ID_W-1:0]      grant_chn_o,
   input  logic                     grant_rdy_i,
   output logic                     arb_busy_o
);

   adma_arb_state_e          state_r, state_nxt_s;
   logic [CHN_ID_W-1:0]      ptr_r, ptr_nxt_s;
   logic [CHN_ID_W-1:0]      owner_r, owner_nxt_s;
   logic [DMA_CHN_ARB_W-1:0] credit_r, credit_nxt_s;
   logic                     grant_vld_r;
   logic                     arb_busy_r;

   logic [DMA_CHN_NUM-1:0]   elig_s;
   logic                     pick_vld_s;
   logic [CHN_ID_W-1:0]      pick_idx_s;
   logic [DMA_CHN_ARB_W-1:0] rate_pick_s;
   logic [DMA_CHN_ARB_W-1:0] weight_s;
   logic [CHN_ID_W-1:0]      owner_inc_s;
   logic                     hs_s;
   logic                     release_s;

   // Per-channel eligibility from global enable, channel enable and request
   always_comb begin
      elig_s = '0;
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
         elig_s[c] = dma_en_i & chn_ctrl_en_i[c] & chn_req_i[c];
      end
   end

   adma_rr_pick #(
      .DMA_CHN_NUM (DMA_CHN_NUM),
      .CHN_ID_W    (CHN_ID_W)
   ) u_pick (
      .elig     (elig_s),
      .ptr      (ptr_r),
      .pick_vld (pick_vld_s),
      .pick_idx (pick_idx_s)
   );

   // A programmed rate of zero still grants one burst
   assign rate_pick_s = chn_arb_rate_i[pick_idx_s];
   assign weight_s    = (rate_pick_s == '0) ? DMA_CHN_ARB_W'(1) : rate_pick_s;
   assign owner_inc_s = (owner_r == CHN_ID_W'(DMA_CHN_NUM - 1)) ? '0 : owner_r + CHN_ID_W'(1);
   assign hs_s        = grant_vld_r & grant_rdy_i;
   // Release on the last credit or when the owner stops being eligible; a same-cycle burst still counts
   assign release_s   = (hs_s & (credit_r == DMA_CHN_ARB_W'(1))) | ~elig_s[owner_r];

   // Next-state and datapath decisions for the arbiter FSM
   always_comb begin
      state_nxt_s  = state_r;
      ptr_nxt_s    = ptr_r;
      owner_nxt_s  = owner_r;
      credit_nxt_s = credit_r;
      case (state_r)
         ARB_IDLE: begin
            if (pick_vld_s) begin
               owner_nxt_s  = pick_idx_s;
               credit_nxt_s = weight_s;
               state_nxt_s  = ARB_GRANT;
            end else begin
               state_nxt_s  = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            if (release_s) begin
               ptr_nxt_s    = owner_inc_s;
               credit_nxt_s = '0;
               state_nxt_s  = ARB_IDLE;
            end else if (hs_s) begin
               credit_nxt_s = credit_r - DMA_CHN_ARB_W'(1);
               state_nxt_s  = ARB_GRANT;
            end else begin
               state_nxt_s  = ARB_GRANT;
            end
         end
         default: begin
            state_nxt_s  = ARB_IDLE;
            credit_nxt_s = '0;
         end
      endcase
   end

   // State, pointer, credit and registered grant outputs
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r     <= ARB_IDLE;
         ptr_r       <= '0;
         owner_r     <= '0;
         credit_r    <= '0;
         grant_vld_r <= 1'b0;
         arb_busy_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         ptr_r       <= ptr_nxt_s;
         owner_r     <= owner_nxt_s;
         credit_r    <= credit_nxt_s;
         grant_vld_r <= (state_nxt_s == ARB_GRANT);
         arb_busy_r  <= (state_nxt_s == ARB_GRANT);
      end
   end

   assign grant_vld_o = grant_vld_r;
   assign arb_busy_o  = arb_busy_r;
   assign grant_chn_o = owner_r;

endmodule

// File: tb/tb_adma_chn_arb.sv
// Self-checking bench for adma_chn_arb: directed scenarios plus random traffic,
// all compared against a burst-counting reference model of the arbitration rules.
module tb_adma_chn_arb;

   localparam int N  = 4;
   localparam int AW = 3;
   localparam int IW = 2;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          dma_en_i;
   logic          chn_ctrl_en_i  [0:N-1];
   logic [AW-1:0] chn_arb_rate_i [0:N-1];
   logic          chn_req_i      [0:N-1];
   logic          grant_vld_o;
   logic [IW-1:0] grant_chn_o;
   logic          grant_rdy_i;
   logic          arb_busy_o;

   int checks = 0;
   int errors = 0;

   // Reference model: who holds the bus, how many bursts remain, where the next scan starts
   bit m_active;
   int m_owner;
   int m_left;
   int m_ptr;
   int hs_q[$];

   adma_chn_arb #(.DMA_CHN_NUM(N), .DMA_CHN_ARB_W(AW)) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .dma_en_i       (dma_en_i),
      .chn_ctrl_en_i  (chn_ctrl_en_i),
      .chn_arb_rate_i (chn_arb_rate_i),
      .chn_req_i      (chn_req_i),
      .grant_vld_o    (grant_vld_o),
      .grant_chn_o    (grant_chn_o),
      .grant_rdy_i    (grant_rdy_i),
      .arb_busy_o     (arb_busy_o)
   );

   always #5 aclk = ~aclk;

   function automatic bit elig(input int c);
      return dma_en_i & chn_ctrl_en_i[c] & chn_req_i[c];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      check({tag, ".vld"},  {31'd0, grant_vld_o}, {31'd0, m_active});
      check({tag, ".busy"}, {31'd0, arb_busy_o},  {31'd0, m_active});
      check({tag, ".chn"},  {30'd0, grant_chn_o}, m_owner);
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_owner  = 0;
      m_left   = 0;
      m_ptr    = 0;
   endtask

   // Apply the arbitration rules to the inputs present before the coming edge
   task automatic model_step();
      if (grant_vld_o && grant_rdy_i) hs_q.push_back(int'(grant_chn_o));
      if (!m_active) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (elig((m_ptr + k) % N)) begin
               m_owner = (m_ptr + k) % N;
               m_active = 1'b1;
            end
         end
         if (m_active) m_left = (chn_arb_rate_i[m_owner] == 0) ? 1 : int'(chn_arb_rate_i[m_owner]);
      end else begin
         if (grant_rdy_i) m_left = m_left - 1;
         if (m_left == 0 || !elig(m_owner)) begin
            m_active = 1'b0;
            m_ptr    = (m_owner + 1) % N;
         end
      end
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge aclk);
      #1;
      check_outs(tag);
   endtask

   task automatic set_req(input logic [N-1:0] r);
      for (int c = 0; c < N; c++) chn_req_i[c] = r[c];
   endtask

   // Asynchronous reset pulse: outputs must clear before any clock edge
   task automatic do_reset(input string tag);
      aresetn = 1'b0;
      #1;
      model_reset();
      check_outs(tag);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
   endtask

   int exp_order[8] = '{0, 1, 1, 2, 3, 3, 3, 0};

   initial begin
      aresetn     = 1'b0;
      dma_en_i    = 1'b0;
      grant_rdy_i = 1'b0;
      for (int c = 0; c < N; c++) begin
         chn_ctrl_en_i[c]  = 1'b0;
         chn_arb_rate_i[c] = '0;
         chn_req_i[c]      = 1'b0;
      end
      model_reset();
      repeat (2) @(posedge aclk);
      #1;
      check_outs("reset");
      aresetn = 1'b1;
      tick("idle_after_reset");
      dma_en_i = 1'b1;
      for (int c = 0; c < N; c++) chn_ctrl_en_i[c] = 1'b1;

      // 1: lone requester ch1, rate 3, re-granted after a one-cycle gap
      chn_arb_rate_i[1] = 3'd3;
      grant_rdy_i = 1'b1;
      set_req(4'b0010);
      repeat (8) tick("t1_single");

      // 2: all request, rates {1,2,0,3}
      do_reset("t2_reset");
      chn_arb_rate_i[0] = 3'd1;
      chn_arb_rate_i[1] = 3'd2;
      chn_arb_rate_i[2] = 3'd0;
      chn_arb_rate_i[3] = 3'd3;
      set_req(4'b1111);
      hs_q.delete();
      repeat (16) tick("t2_all");
      for (int i = 0; i < 8; i++)
         check($sformatf("t2_order[%0d]", i), (hs_q.size() > i) ? hs_q[i] : -1, exp_order[i]);

      // 3: ch0 withdraws after two bursts, ch1 follows after the gap
      do_reset("t3_reset");
      chn_arb_rate_i[0] = 3'd4;
      set_req(4'b0011);
      repeat (3) tick("t3_grant");
      set_req(4'b0010);
      tick("t3_withdraw");
      check("t3_gap", {31'd0, grant_vld_o}, 32'd0);
      tick("t3_next");
      check("t3_ch1", {30'd0, grant_chn_o}, 32'd1);

      // 4: back-pressure on ch2 holds the grant and credit
      do_reset("t4_reset");
      chn_arb_rate_i[2] = 3'd5;
      set_req(4'b0100);
      grant_rdy_i = 1'b0;
      repeat (6) tick("t4_stall");
      grant_rdy_i = 1'b1;
      repeat (7) tick("t4_drain");

      // 5: global disable during a ch3 grant, then re-enable with all requesting
      do_reset("t5_reset");
      chn_arb_rate_i[3] = 3'd3;
      set_req(4'b1000);
      repeat (2) tick("t5_grant");
      dma_en_i = 1'b0;
      set_req(4'b1111);
      repeat (3) tick("t5_disabled");
      dma_en_i = 1'b1;
      repeat (2) tick("t5_reenable");
      check("t5_ch0", {30'd0, grant_chn_o}, 32'd0);

      // 6: reset mid-grant on ch1, first grant afterwards scans from ch0
      do_reset("t6_reset");
      set_req(4'b0010);
      repeat (2) tick("t6_grant");
      do_reset("t6_async");
      set_req(4'b0110);
      repeat (2) tick("t6_after");
      check("t6_ch1", {30'd0, grant_chn_o}, 32'd1);

      // Random traffic, including mid-grant rate changes and occasional resets
      for (int n = 0; n < 500; n++) begin
         dma_en_i    = ($urandom_range(0, 15) != 0);
         grant_rdy_i = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < N; c++) begin
            chn_ctrl_en_i[c]  = ($urandom_range(0, 7) != 0);
            chn_req_i[c]      = ($urandom_range(0, 3) != 0);
            chn_arb_rate_i[c] = AW'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 99) == 0) do_reset("rnd_reset");
         else tick("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adma_chn_arb.md
Name: adma_chn_arb

Overview:
Weighted round-robin channel arbiter for the AXI DMA. It shares the single AXI4 master datapath between DMA_CHN_NUM channels and grants one channel at a time. The granted channel may issue up to its programmed chn_arb_rate bursts, then ownership rotates. Its inputs are the CSR outputs dma_en, chn_ctrl_en and chn_arb_rate, plus per-channel burst-ready requests. Its grant drives the burst issue stage.

Parameters:
DMA_CHN_NUM, 4, number of DMA channels; must be >= 2.
DMA_CHN_ARB_W, 3, width of per-channel arbitration weight.
CHN_ID_W, $clog2(DMA_CHN_NUM), derived; not to be overridden.

Ports:
aclk  in  1  clock.
aresetn  in  1  reset, asynchronous, active-low.
dma_en_i  in  1  global DMA enable (CSR).
chn_ctrl_en_i  in  1 [0:DMA_CHN_NUM-1]  per-channel enable (CSR).
chn_arb_rate_i  in  DMA_CHN_ARB_W [0:DMA_CHN_NUM-1]  bursts per grant (CSR).
chn_req_i  in  1 [0:DMA_CHN_NUM-1]  channel has a burst ready to issue.
grant_vld_o  out  1  a grant is active.
grant_chn_o  out  CHN_ID_W  index of the granted channel.
grant_rdy_i  in  1  datapath accepted one burst from the granted channel.
arb_busy_o  out  1  the state machine is in GRANT.

Behaviour:
- Interface: one clock, aclk. Reset aresetn is asynchronous and active-low.
- Eligibility: elig[c] = dma_en_i & chn_ctrl_en_i[c] & chn_req_i[c].
- Weight: weight[c] = (chn_arb_rate_i[c]==0) ? 1 : chn_arb_rate_i[c]. Range is 1..2^DMA_CHN_ARB_W-1.
- Registered state: fsm {IDLE, GRANT}; ptr (CHN_ID_W bits, next channel with priority); owner; credit (DMA_CHN_ARB_W bits).
- Reset values:
  - fsm=IDLE, ptr=0, owner=0, credit=0.
  - grant_vld_o=0, grant_chn_o=0, arb_busy_o=0.
- All outputs are registered. grant_vld_o=arb_busy_o=(fsm==GRANT). grant_chn_o=owner.
- Pick function: first c with elig[c], scanning ptr, ptr+1, … mod DMA_CHN_NUM.
- IDLE:
  - If any elig in cycle T: owner←pick, credit←weight[pick], fsm←GRANT.
  - grant_vld_o rises at T+1, so arbitration latency is 1 cycle.
  - If nothing is eligible, stay in IDLE.
- GRANT:
  - Handshake = grant_vld_o & grant_rdy_i. Each handshake is one burst and decrements credit.
  - Handshake with credit==1 (last credit): ptr←owner+1 mod N, fsm←IDLE.
  - After that release, grant_vld_o is low for exactly one cycle before any re-grant. This includes the same channel when it is the only requester.
  - Withdrawal: elig[owner]==0 with no handshake in the cycle → ptr←owner+1, fsm←IDLE. grant_vld_o falls the next cycle and the remaining credit is forfeited.
  - Handshake and elig[owner] drop in the same cycle: the burst counts, then release as in the withdrawal case.
  - grant_rdy_i low: grant_vld_o and grant_chn_o hold stable and credit is unchanged. There is no timeout.
- chn_arb_rate_i is sampled only when a grant is loaded. Changes mid-grant take effect at the next grant of that channel.
- grant_rdy_i is ignored while grant_vld_o=0.
- aresetn asserted mid-grant: all outputs clear immediately (asynchronously). After reset release, the first grant follows ptr=0 priority.
- Credit arithmetic: unsigned DMA_CHN_ARB_W bits. It never underflows because release occurs at credit==1.

Decomposition:
- Package adma_pkg holds:
  - enum adma_arb_state_e {ARB_IDLE, ARB_GRANT};
  - CHN_ID_W helper function (clog2 wrapper).
- Sub-module adma_rr_pick: combinational. Inputs are the elig vector and ptr; outputs are pick_vld and pick_idx.

Test Plan:
1. Only ch1 requests, rate=3, grant_rdy_i=1 → grant_vld_o one cycle after req; 3 handshakes with grant_chn_o=1; one low cycle; re-grant to ch1.
2. All 4 channels request continuously, rates {1,2,0,3}, rdy=1 → handshake order 0,1,1,2,3,3,3,0,… with a one-cycle gap between owners (rate 0 gives 1 burst).
3. ch0 rate=4: drop chn_req_i[0] after 2 handshakes → grant_vld_o low the next cycle; ch1 (requesting) granted the cycle after that.
4. Grant active on ch2, grant_rdy_i held 0 for 5 cycles → grant_chn_o=2 stable and credit unchanged. Then rdy=1 → full weight is consumed.
5. dma_en_i=0 during a ch3 grant → grant_vld_o falls next cycle, no grants while disabled. Re-enable with all channels requesting → ch0 granted (ptr=3+1 mod 4).
6. aresetn pulsed during a ch1 grant → grant_vld_o=0 and grant_chn_o=0 immediately. After release with ch1 and ch2 requesting → ch1 granted first (ptr=0 scan).
